// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered-read or FWFT output,
// almost-full/empty thresholds, occupancy count, flush and error pulses.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   clr           synchronous flush (wins over w_en/r_en)
//   w_en, data_in write request and data
//   r_en          read request (pop/acknowledge in FWFT mode)
//   data_out      read data (registered, or mem head when FWFT=1)
//   full, empty, almost_full, almost_empty, count  status from occupancy
//   overflow, underflow  one-cycle pulses for rejected write/read
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W-1:0]     wr_idx;
    logic [ADDR_W-1:0]     rd_idx;
    logic                  rd_acc;
    logic                  wr_acc;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    // The wrap bit makes the pointer difference span 0..DEPTH, so the
    // occupancy comes straight from registered state with no extra counter.
    assign count = wr_ptr - rd_ptr;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));

    // A write into a full FIFO succeeds only when a read frees a slot
    // on the same edge.
    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            overflow  <= w_en & ~wr_acc;
            underflow <= r_en & empty;
        end
    end

    // Storage is not reset; the rst term keeps a write that coincides
    // with a held reset from landing in the array.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr && !rst) begin
            mem[wr_idx] <= data_in;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = mem[rd_idx];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (clr) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem[rd_idx];
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a registered-read and an FWFT
// instance share stimulus and are compared against a queue model.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       w_en;
    logic       r_en;
    logic [7:0] din;

    logic [7:0] dout0;
    logic       full0;
    logic       empty0;
    logic       af0;
    logic       ae0;
    logic [4:0] cnt0;
    logic       ovf0;
    logic       udf0;

    logic [7:0] dout1;
    logic       full1;
    logic       empty1;
    logic       af1;
    logic       ae1;
    logic [4:0] cnt1;
    logic       ovf1;
    logic       udf1;

    int vecs;
    int errs;

    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_udf;

    sync_fifo_param #(.FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .r_en(r_en),
        .data_in(din), .data_out(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .r_en(r_en),
        .data_in(din), .data_out(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; the model applies the FIFO rules to the inputs
    // that are stable ahead of that edge.
    task automatic cycle();
        int   n;
        logic rd_ok;
        logic wr_ok;
        n = q.size();
        if (rst) begin
            q.delete();
            exp_dout = 8'h00;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else if (clr) begin
            q.delete();
            exp_dout = 8'h00;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            rd_ok = r_en && (n > 0);
            wr_ok = w_en && ((n < 16) || rd_ok);
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
            exp_ovf = w_en && !wr_ok;
            exp_udf = r_en && (n == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en = 1'b0;
        r_en = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        din = 8'h00;
        #3;
        vecs++;
        if (cnt0 !== 5'd0 || empty0 !== 1'b1 || ae0 !== 1'b1 ||
            full0 !== 1'b0 || af0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: cnt=%0d e=%b ae=%b f=%b af=%b, need 0 1 1 0 0",
                     cnt0, empty0, ae0, full0, af0);
        end
        vecs++;
        if (dout0 !== 8'h00 || ovf0 !== 1'b0 || udf0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_out: dout=%h ovf=%b udf=%b, need 00 0 0",
                     dout0, ovf0, udf0);
        end
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1;
            din  = 8'(i);
            cycle();
            vecs++;
            if (cnt0 !== 5'(i + 1) || ovf0 !== 1'b0) begin
                errs++;
                $display("FAIL fill_count: i=%0d cnt=%0d ovf=%b, need %0d 0",
                         i, cnt0, ovf0, i + 1);
            end
            vecs++;
            if (ae0 !== (i + 1 <= 2) || af0 !== (i + 1 >= 14) ||
                full0 !== (i + 1 == 16) || empty0 !== 1'b0) begin
                errs++;
                $display("FAIL fill_flags: cnt=%0d ae=%b af=%b f=%b e=%b",
                         i + 1, ae0, af0, full0, empty0);
            end
        end
        idle();
    endtask

    task automatic test_overflow();
        w_en = 1'b1;
        din  = 8'hAA;
        cycle();
        idle();
        vecs++;
        if (ovf0 !== 1'b1 || cnt0 !== 5'd16 || ovf1 !== 1'b1) begin
            errs++;
            $display("FAIL ovf_pulse: ovf=%b/%b cnt=%0d, need 1 16",
                     ovf0, ovf1, cnt0);
        end
        cycle();
        vecs++;
        if (ovf0 !== 1'b0 || cnt0 !== 5'd16) begin
            errs++;
            $display("FAIL ovf_single: ovf=%b cnt=%0d, need 0 16", ovf0, cnt0);
        end
        for (int i = 0; i < 16; i++) begin
            vecs++;
            if (dout1 !== 8'(i)) begin
                errs++;
                $display("FAIL ovf_fwft_head: i=%0d got %h need %h",
                         i, dout1, 8'(i));
            end
            r_en = 1'b1;
            cycle();
            vecs++;
            if (dout0 !== 8'(i) || dout0 !== exp_dout) begin
                errs++;
                $display("FAIL ovf_drain: i=%0d got %h need %h", i, dout0, 8'(i));
            end
        end
        idle();
        vecs++;
        if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin
            errs++;
            $display("FAIL ovf_empty: e=%b cnt=%0d, need 1 0", empty0, cnt0);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] oldest;
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1;
            din  = 8'($urandom_range(0, 8'h54));
            cycle();
        end
        oldest = q[0];
        w_en = 1'b1;
        r_en = 1'b1;
        din  = 8'h55;
        cycle();
        idle();
        vecs++;
        if (cnt0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b0) begin
            errs++;
            $display("FAIL simul_count: cnt=%0d f=%b ovf=%b, need 16 1 0",
                     cnt0, full0, ovf0);
        end
        vecs++;
        if (dout0 !== oldest) begin
            errs++;
            $display("FAIL simul_oldest: got %h need %h", dout0, oldest);
        end
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            cycle();
            vecs++;
            if (dout0 !== exp_dout) begin
                errs++;
                $display("FAIL simul_drain: i=%0d got %h need %h",
                         i, dout0, exp_dout);
            end
        end
        idle();
        vecs++;
        if (dout0 !== 8'h55 || cnt0 !== 5'd0) begin
            errs++;
            $display("FAIL simul_last: got %h cnt=%0d, need 55 0", dout0, cnt0);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] held;
        held = dout0;
        r_en = 1'b1;
        cycle();
        idle();
        vecs++;
        if (udf0 !== 1'b1 || dout0 !== held || cnt0 !== 5'd0) begin
            errs++;
            $display("FAIL udf_empty: udf=%b dout=%h cnt=%0d, need 1 %h 0",
                     udf0, dout0, cnt0, held);
        end
        w_en = 1'b1;
        r_en = 1'b1;
        din  = 8'h33;
        cycle();
        idle();
        vecs++;
        if (udf0 !== 1'b1 || cnt0 !== 5'd1 || ovf0 !== 1'b0) begin
            errs++;
            $display("FAIL udf_wr_rd: udf=%b cnt=%0d ovf=%b, need 1 1 0",
                     udf0, cnt0, ovf0);
        end
        cycle();
        vecs++;
        if (udf0 !== 1'b0) begin
            errs++;
            $display("FAIL udf_single: udf=%b need 0", udf0);
        end
        r_en = 1'b1;
        cycle();
        idle();
        vecs++;
        if (dout0 !== 8'h33 || empty0 !== 1'b1) begin
            errs++;
            $display("FAIL udf_readback: got %h e=%b, need 33 1", dout0, empty0);
        end
    endtask

    task automatic test_fwft();
        w_en = 1'b1;
        din  = 8'h11;
        cycle();
        idle();
        vecs++;
        if (dout1 !== 8'h11 || empty1 !== 1'b0) begin
            errs++;
            $display("FAIL fwft_visible: dout=%h e=%b, need 11 0", dout1, empty1);
        end
        r_en = 1'b1;
        cycle();
        idle();
        vecs++;
        if (empty1 !== 1'b1 || cnt1 !== 5'd0) begin
            errs++;
            $display("FAIL fwft_pop: e=%b cnt=%0d, need 1 0", empty1, cnt1);
        end
    endtask

    task automatic test_wrap_random();
        int writes;
        writes = 0;
        for (int i = 0; i < 120; i++) begin
            if (i < 40) begin
                w_en = (i % 2 == 0);
                r_en = (i % 2 == 1);
            end else begin
                w_en = ($urandom_range(0, 99) < 60);
                r_en = ($urandom_range(0, 99) < 50);
            end
            din = 8'($urandom);
            if (w_en && (q.size() < 16 || (r_en && q.size() > 0))) writes++;
            cycle();
            vecs++;
            if (cnt0 !== 5'(q.size()) || dout0 !== exp_dout ||
                ovf0 !== exp_ovf || udf0 !== exp_udf) begin
                errs++;
                $display("FAIL wrap_state: i=%0d cnt=%0d/%0d dout=%h/%h ovf=%b/%b udf=%b/%b",
                         i, cnt0, q.size(), dout0, exp_dout, ovf0, exp_ovf,
                         udf0, exp_udf);
            end
            vecs++;
            if (full0 !== (q.size() == 16) || empty0 !== (q.size() == 0) ||
                af0 !== (q.size() >= 14) || ae0 !== (q.size() <= 2) ||
                cnt1 !== 5'(q.size())) begin
                errs++;
                $display("FAIL wrap_flags: i=%0d n=%0d f=%b e=%b af=%b ae=%b",
                         i, q.size(), full0, empty0, af0, ae0);
            end
            if (q.size() > 0) begin
                vecs++;
                if (dout1 !== q[0]) begin
                    errs++;
                    $display("FAIL wrap_fwft: i=%0d got %h need %h", i, dout1, q[0]);
                end
            end
        end
        vecs++;
        if (writes < 32) begin
            errs++;
            $display("FAIL wrap_coverage: writes=%0d need >=32", writes);
        end
        if (q.size() < 16) begin
            w_en = 1'b1;
            din  = 8'h77;
            cycle();
        end
        clr  = 1'b1;
        w_en = 1'b1;
        r_en = 1'b1;
        din  = 8'hEE;
        cycle();
        idle();
        vecs++;
        if (cnt0 !== 5'd0 || empty0 !== 1'b1 || ae0 !== 1'b1 ||
            ovf0 !== 1'b0 || udf0 !== 1'b0 || dout0 !== 8'h00) begin
            errs++;
            $display("FAIL clr_state: cnt=%0d e=%b ae=%b ovf=%b udf=%b dout=%h",
                     cnt0, empty0, ae0, ovf0, udf0, dout0);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 5; i++) begin
            w_en = 1'b1;
            din  = 8'(8'hC0 + i);
            cycle();
        end
        w_en = 1'b1;
        r_en = 1'b1;
        din  = 8'hDD;
        #2;
        rst = 1'b1;
        q.delete();
        exp_dout = 8'h00;
        #1;
        vecs++;
        if (cnt0 !== 5'd0 || empty0 !== 1'b1 || ae0 !== 1'b1 ||
            full0 !== 1'b0 || af0 !== 1'b0 || dout0 !== 8'h00) begin
            errs++;
            $display("FAIL rst_mid_now: cnt=%0d e=%b ae=%b f=%b af=%b dout=%h",
                     cnt0, empty0, ae0, full0, af0, dout0);
        end
        @(posedge clk);
        #1;
        idle();
        #2;
        rst = 1'b0;
        cycle();
        vecs++;
        if (cnt0 !== 5'd0 || cnt1 !== 5'd0 || ovf0 !== 1'b0 || udf0 !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_after: cnt=%0d/%0d ovf=%b udf=%b, need 0 0 0",
                     cnt0, cnt1, ovf0, udf0);
        end
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_simul_full();
        test_underflow();
        test_fwft();
        test_wrap_random();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
